// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states, and the
// clocks-per-bit calculation reused by the receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_param_baud_tick_gen.sv
// Bit-period counter 0..DIV-1 with synchronous restart; tick_c marks the
// last cycle of each bit period.
module baud_tick_gen #(
  parameter int unsigned DIV = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-word holding register so that
// consecutive frames leave the line with no idle gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 TxD_start,
  input  logic [DATA_BITS-1:0] TxD_data,
  output logic                 TxD,
  output logic                 TxD_busy,
  output logic                 TxD_active
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned IDX_W = 4;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_FREQ/BAUD gives fewer than 2 clocks per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end

  tx_state_t            state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [DATA_BITS-1:0] sh_q, sh_n;
  logic                 par_q, par_n;
  logic                 tx_n, active_n;
  logic                 load, restart, baud_tick;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;

  baud_tick_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick_c  (baud_tick)
  );

  assign TxD_busy = hold_full;

  // Shifter next state; a load from the holding register overrides everything.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    sh_n     = sh_q;
    par_n    = par_q;
    load     = 1'b0;
    restart  = 1'b0;
    tx_n     = 1'b1;
    active_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        load    = hold_full;
      end
      ST_START: begin
        if (baud_tick) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + IDX_W'(1);
            sh_n  = sh_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_n = ST_STOP;
          idx_n   = '0;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_n = '0;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (load) begin
      state_n = ST_START;
      idx_n   = '0;
      sh_n    = hold_data;
      par_n   = (PARITY == PAR_ODD) ? ~(^hold_data) : (^hold_data);
      restart = 1'b1;
    end

    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = sh_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
    active_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      TxD        <= 1'b1;
      TxD_active <= 1'b0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      sh_q       <= sh_n;
      par_q      <= par_n;
      TxD        <= tx_n;
      TxD_active <= active_n;
      // Load and accept are exclusive: load needs a full register, accept an empty one.
      if (load) begin
        hold_full <= 1'b0;
      end else if (TxD_start && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= TxD_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: five instances cover 8N1, 8E1, 8O1,
// 7N2 at 16 clocks/bit and the default 217 clocks/bit configuration.
module tb_uart_tx_param;

  logic       clk;
  logic       rst;
  logic       start [5];
  logic [8:0] data  [5];
  logic       txd   [5];
  logic       busy  [5];
  logic       act   [5];

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .TxD_start(start[0]), .TxD_data(data[0][7:0]),
    .TxD(txd[0]), .TxD_busy(busy[0]), .TxD_active(act[0]));

  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .TxD_start(start[1]), .TxD_data(data[1][7:0]),
    .TxD(txd[1]), .TxD_busy(busy[1]), .TxD_active(act[1]));

  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .TxD_start(start[2]), .TxD_data(data[2][7:0]),
    .TxD(txd[2]), .TxD_busy(busy[2]), .TxD_active(act[2]));

  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .TxD_start(start[3]), .TxD_data(data[3][6:0]),
    .TxD(txd[3]), .TxD_busy(busy[3]), .TxD_active(act[3]));

  uart_tx_param u_dflt (
    .clk(clk), .rst(rst), .TxD_start(start[4]), .TxD_data(data[4][7:0]),
    .TxD(txd[4]), .TxD_busy(busy[4]), .TxD_active(act[4]));

  // Request one word; returns on the falling edge one cycle after the accept.
  task automatic send(input int idx, input logic [8:0] w, input string name);
    @(negedge clk);
    total++;
    if (busy[idx] !== 1'b0) begin
      bad++;
      $display("FAIL %s ready: busy=%b want 0", name, busy[idx]);
    end
    start[idx] = 1'b1;
    data[idx]  = w;
    @(negedge clk);
    start[idx] = 1'b0;
    total++;
    if (busy[idx] !== 1'b1) begin
      bad++;
      $display("FAIL %s held: busy=%b want 1", name, busy[idx]);
    end
  endtask

  // Follow one frame from the next cycle; exp[i] is the i-th line bit.
  task automatic watch_frame(input int idx, input logic [15:0] exp, input int nbits,
                             input int div, input string name);
    int wrong;
    total++;
    for (int b = 0; b < nbits; b++) begin
      wrong = 0;
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0 && busy[idx] !== 1'b0) begin
          bad++;
          $display("FAIL %s drain: busy=%b want 0 at first start cycle", name, busy[idx]);
        end
        if (txd[idx] !== exp[b] || act[idx] !== 1'b1) wrong++;
      end
      total++;
      if (wrong != 0) begin
        bad++;
        $display("FAIL %s bit%0d: %0d of %0d cycles wrong, want txd=%b active=1",
                 name, b, wrong, div, exp[b]);
      end
    end
  endtask

  task automatic watch_idle(input int idx, input int cycles, input string name);
    int wrong = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (txd[idx] !== 1'b1 || act[idx] !== 1'b0) wrong++;
    end
    total++;
    if (wrong != 0) begin
      bad++;
      $display("FAIL %s idle: %0d of %0d cycles not idle, want txd=1 active=0",
               name, wrong, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (txd[i] !== 1'b1 || busy[i] !== 1'b0 || act[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset inst%0d: txd=%b busy=%b active=%b want 1 0 0",
                 i, txd[i], busy[i], act[i]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    send(0, 9'h055, "8n1_55");
    watch_frame(0, 16'h02AA, 10, 16, "8n1_55");
    watch_idle(0, 20, "8n1_55_end");
  endtask

  task automatic test_parity();
    send(1, 9'h0A5, "8e1_a5");
    watch_frame(1, 16'h054A, 11, 16, "8e1_a5");
    watch_idle(1, 20, "8e1_a5_end");
    send(2, 9'h0A5, "8o1_a5");
    watch_frame(2, 16'h074A, 11, 16, "8o1_a5");
    watch_idle(2, 20, "8o1_a5_end");
  endtask

  task automatic test_7n2();
    send(3, 9'h07F, "7n2_7f");
    watch_frame(3, 16'h03FE, 10, 16, "7n2_7f");
    watch_idle(3, 20, "7n2_7f_end");
  endtask

  task automatic test_back_to_back();
    send(0, 9'h012, "b2b_12");
    fork
      begin
        watch_frame(0, 16'h0224, 10, 16, "b2b_12");
        total++;
        if (busy[0] !== 1'b1) begin
          bad++;
          $display("FAIL b2b_hold_end: busy=%b want 1 on last stop cycle", busy[0]);
        end
        watch_frame(0, 16'h0268, 10, 16, "b2b_34");
        watch_idle(0, 40, "b2b_no_third");
      end
      begin
        repeat (20) @(negedge clk);
        send(0, 9'h034, "b2b_34");
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        data[0]  = 9'h0FF;
        repeat (10) @(negedge clk);
        start[0] = 1'b0;
        total++;
        if (busy[0] !== 1'b1) begin
          bad++;
          $display("FAIL b2b_drop: busy=%b want 1", busy[0]);
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    send(0, 9'h0C3, "rst_c3");
    repeat (40) @(negedge clk);
    send(0, 9'h05A, "rst_5a");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || act[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_abort: txd=%b busy=%b active=%b want 1 0 0",
               txd[0], busy[0], act[0]);
    end
    watch_idle(0, 200, "rst_abort");
  endtask

  task automatic test_default_div();
    send(4, 9'h000, "dflt_00");
    watch_frame(4, 16'h0200, 10, 217, "dflt_00");
    watch_idle(4, 20, "dflt_00_end");
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start[i] = 1'b0;
      data[i]  = '0;
    end
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_reset_mid_frame();
    test_default_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised RS-232 transmitter for the serial link: serialises one word per request into an asynchronous frame (start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits), with each bit held for a fixed number of clocks derived from CLK_FREQ/BAUD. A one-entry holding register lets the host queue the next word while the current frame is on the line, so frames go out back-to-back with no idle gap. Sits between the host-side data source and the TxD pad.

## Interface
- CLK_FREQ, 25000000, system clock frequency in Hz
- BAUD, 115200, line bit rate
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- TxD_start  in  1  request; accepted on a cycle where TxD_start=1 and TxD_busy=0
- TxD_data  in  DATA_BITS  word to send, sampled on the accept cycle only
- TxD  out  1  serial line, idle high
- TxD_busy  out  1  holding register full; requests ignored while high
- TxD_active  out  1  frame currently being shifted on TxD

## Operation
- Derived constant DIV = (CLK_FREQ + BAUD/2) / BAUD, integer; DIV >= 2 required (elaboration error otherwise). Default gives 217.
- Frame length FRAME = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits.
- Parity bit: even = XOR of all DATA_BITS data bits; odd = its inverse.
- Shifter FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TxD=1. If holding register full, load shifter from it, clear holding, go START.
- START: TxD=0 for DIV cycles -> DATA.
- DATA: bit index 0..DATA_BITS-1, each DIV cycles; after last -> PARITY if PARITY!=0, else STOP.
- PARITY: parity bit for DIV cycles -> STOP.
- STOP: TxD=1 for STOP_BITS*DIV cycles; at end, if holding full, load and go directly to START (no idle cycle); else IDLE.
- Accept: word written into holding register; holding register fills even when FSM idle (it drains next cycle).
- Requests while TxD_busy=1 are dropped, never queued, never corrupt the held word.
- Bit-period counter restarts at 0 on every shifter load; no free-running baud phase.
- Reset: TxD=1, TxD_busy=0, TxD_active=0, FSM IDLE, counters 0, holding register empty (data cleared to 0). Reset mid-frame aborts the frame; TxD high on the cycle after rst is sampled; held word discarded.

## Timing
- All outputs registered except TxD_busy, driven directly from the holding-full flop.
- Accept at cycle N (FSM idle): holding full N+1, shifter loads at N+1, TxD falls and TxD_active rises at N+2, TxD_busy low again at N+2.
- Each bit occupies exactly DIV cycles; full frame FRAME*DIV cycles from TxD fall to last stop-bit cycle.
- Back-to-back: next start bit begins the cycle after the final stop-bit cycle; TxD_active stays high across the boundary.
- TxD_busy falls the cycle after the holding word moves to the shifter; a request in that same falling cycle is accepted.

## Structure
- Shared package uart_pkg: parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), FSM state enum, DIV computation function shared with the future receiver.
- Sub-module baud_tick_gen: counter 0..DIV-1 with synchronous restart input, one-cycle tick at terminal count; FSM advances on tick.

## Test plan
- CLK_FREQ=1600, BAUD=100 (DIV=16), 8N1, send 0x55 -> TxD low 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, high 16 cycles; frame 160 cycles; TxD_active high exactly 160 cycles.
- Same clocks, PARITY=2 then PARITY=1, send 0xA5 -> data 1,0,1,0,0,1,0,1, parity bit 0 (even) / 1 (odd), frame 176 cycles.
- DATA_BITS=7, STOP_BITS=2, PARITY=0, send 0x7F -> start, seven 1s, stop high 32 cycles, frame 160 cycles.
- Back-to-back 0x12 then 0x34 (second request while first in flight) -> TxD_busy high until second loads; second start bit immediately follows first stop bit; third request during busy dropped, line shows only 0x12, 0x34.
- Assert rst for one cycle mid-DATA with a word held -> TxD=1, TxD_busy=0, TxD_active=0 next cycle; no further frame emitted.
- Default parameters (DIV=217), send 0x00 -> each bit period measured as 217 cycles.
